uart_tx_bus_slave: RTL and testbench
====================================

// Module: uart_tx_bus_slave
// PURPOSE
//   Memory-mapped UART transmitter on the openmips data bus (ce/we/addr/sel/data).
//   Acts as a bus responder alongside data_ram; the SoC address decode drives its ce_i.
//   CPU stores push bytes into a TX FIFO. A serial FSM emits 8N1 frames on uart_txd_o.
//   uart_int_o is a level interrupt; the SoC places it on int_i as uart_int.
// PARAMETERS
//   FIFO_DEPTH_LOG2  3        TX FIFO holds 2**FIFO_DEPTH_LOG2 bytes (8)
//   BAUD_DIV_RESET   16'd433  reset value of BAUDDIV (50 MHz / 115200 - 1)
// PORTS
//   clk         in   1   system clock; all state changes on rising edge
//   rst         in   1   synchronous reset, active high
//   ce_i        in   1   block selected for this bus cycle
//   we_i        in   1   1 = write, 0 = read
//   addr_i      in   32  byte address relative to block base; only [3:2] decoded
//   sel_i       in   4   byte enables; sel_i[0] = data_i[7:0]
//   data_i      in   32  write data
//   data_o      out  32  read data (combinational)
//   uart_txd_o  out  1   serial output, idle high
//   uart_int_o  out  1   interrupt request, level, active high
// BEHAVIOUR
//   Register map (addr_i[3:2]):
//     0 TXDATA  W: push data_i[7:0] if sel_i[0]. R: 0.
//     1 STATUS  R: [0] busy (FSM != IDLE), [1] fifo empty, [2] fifo full,
//                  [3] overflow (sticky), [15:8] fifo count; other bits 0.
//               W: data_i[3]=1 with sel_i[0] clears overflow.
//     2 CTRL    R/W via sel_i[0]: [0] tx_enable, [1] irq_enable; other bits read 0.
//     3 BAUDDIV R/W 16 bits; sel_i[0] writes [7:0], sel_i[1] writes [15:8].
//   Bus protocol:
//     - Read: data_o is valid in the same cycle when ce_i & ~we_i; otherwise data_o = 0.
//     - Write: takes effect at the rising edge where ce_i & we_i.
//     - No wait states.
//   Reset values:
//     - txd = 1, int = 0, FIFO empty, overflow = 0.
//     - CTRL = 2'b01, BAUDDIV = BAUD_DIV_RESET, FSM = IDLE, data_o = 0.
//   Bit timing:
//     - Each bit lasts BAUDDIV+1 cycles, so one frame is 10*(BAUDDIV+1) cycles.
//     - The bit counter loads BAUDDIV at each bit start and counts down to 0.
//     - A BAUDDIV write mid-frame applies from the next bit start.
//   FSM:
//     - IDLE: txd=1. Pop the FIFO and go to START when tx_enable & ~empty.
//     - START: txd=0 for one bit, then go to DATA.
//     - DATA: send 8 bits LSB first, with a 3-bit index, then go to STOP.
//     - STOP: txd=1 for one bit. At bit end, pop and go to START if tx_enable & ~empty
//       (back-to-back frames, no gap); otherwise go to IDLE.
//   Latency: a TXDATA write at edge E into an empty FIFO with FSM IDLE pops at edge E+1.
//     uart_txd_o goes low after E+1.
//   FIFO:
//     - Push when full: byte dropped, overflow set, count unchanged.
//     - Push and pop in the same cycle while full: push accepted, count unchanged.
//     - Push and pop in the same cycle while empty: cannot occur (pop requires ~empty).
//     - Pointers wrap modulo depth; count width is FIFO_DEPTH_LOG2+1.
//   tx_enable cleared mid-frame: the current frame completes and no further pops occur.
//     FIFO contents are retained.
//   uart_int_o = irq_enable & empty & (FSM == IDLE). It is a registered output,
//     updated one cycle after the condition changes.
//   rst mid-frame: the next edge forces the full reset state, txd goes to 1, and
//     queued bytes are lost.
// TESTING
//   1. After reset, read STATUS -> 0x00000002; read BAUDDIV -> 433; uart_txd_o=1.
//   2. BAUDDIV=3, write TXDATA 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit.
//      First low comes 1 edge after the write; 40 cycles per frame.
//   3. BAUDDIV=1, push 0x55 and 0x0F -> two frames with no idle gap; STATUS busy=1 throughout.
//      Then busy=0 and empty=1.
//   4. CTRL=0, push 9 bytes -> count=8, full=1, overflow=1.
//      Clear overflow with STATUS write 0x8 -> overflow=0.
//      Set CTRL=1 -> bytes 1..8 transmitted in order; 9th byte absent.
//   5. CTRL=3, push 1 byte, BAUDDIV=2 -> uart_int_o=0 during the frame.
//      uart_int_o rises 1 cycle after FSM returns to IDLE.
//      Writing CTRL=1 drops uart_int_o next cycle.
//   6. Assert rst for 1 cycle during the DATA state with 3 bytes queued.
//      Required: txd=1, FIFO empty, CTRL=1, BAUDDIV=433 after the edge, and no further frames.

Source files
------------

// File: rtl/uart_tx_bus_slave_if.sv
// Bus bundle for the memory-mapped UART transmitter: openmips-style ce/we/addr/sel/data.
// The master drives the request side; the slave returns combinational read data.
interface uart_tx_bus_slave_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport slave  (input ce_i, we_i, addr_i, sel_i, data_i, output data_o);
  modport master (output ce_i, we_i, addr_i, sel_i, data_i, input data_o);
endinterface

// File: rtl/uart_tx_bus_slave.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sticky overflow and a level interrupt.
// Registers: 0 TXDATA, 1 STATUS, 2 CTRL, 3 BAUDDIV (selected by addr_i[3:2]).
module uart_tx_bus_slave #(
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] BAUD_DIV_RESET  = 16'd433
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_bus_slave_if.slave   bus,
  output logic                 uart_txd_o,
  output logic                 uart_int_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                     r_state;
  logic [15:0]                r_baudDiv;
  logic [15:0]                r_bitCnt;
  logic [7:0]                 r_shift;
  logic [2:0]                 r_bitIdx;
  logic [1:0]                 r_ctrl;
  logic                       r_overflow;
  logic                       r_txd;
  logic                       r_int;
  logic [7:0]                 r_fifo [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wrPtr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rdPtr;
  logic [CW-1:0]              r_count;

  logic       w_wr;
  logic       w_rd;
  logic [1:0] w_regSel;
  logic       w_empty;
  logic       w_full;
  logic       w_bitEnd;
  logic       w_pop;
  logic       w_pushReq;
  logic       w_push;
  logic       w_busy;
  logic       w_unused;

  assign w_wr      = bus.ce_i & bus.we_i;
  assign w_rd      = bus.ce_i & ~bus.we_i;
  assign w_regSel  = bus.addr_i[3:2];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_bitEnd  = (r_bitCnt == 16'd0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_unused  = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.data_i[31:16], bus.sel_i[3:2]};

  // Pops happen only when a new frame starts: from IDLE, or at the end of a stop bit.
  assign w_pop     = r_ctrl[0] & ~w_empty &
                     ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bitEnd));
  assign w_pushReq = w_wr & (w_regSel == 2'd0) & bus.sel_i[0];
  assign w_push    = w_pushReq & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
      if (w_pushReq & ~w_push)
        r_overflow <= 1'b1;
      else if (w_wr & (w_regSel == 2'd1) & bus.sel_i[0] & bus.data_i[3])
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wrPtr] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= 2'b01;
      r_baudDiv <= BAUD_DIV_RESET;
    end else if (w_wr) begin
      if ((w_regSel == 2'd2) & bus.sel_i[0]) r_ctrl <= bus.data_i[1:0];
      if ((w_regSel == 2'd3) & bus.sel_i[0]) r_baudDiv[7:0]  <= bus.data_i[7:0];
      if ((w_regSel == 2'd3) & bus.sel_i[1]) r_baudDiv[15:8] <= bus.data_i[15:8];
    end
  end

  // The bit counter reloads from BAUDDIV at every bit start, so divider writes land on the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_txd    <= 1'b1;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_int    <= 1'b0;
    end else begin
      r_int <= r_ctrl[1] & w_empty & (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_state  <= S_START;
            r_txd    <= 1'b0;
            r_bitCnt <= r_baudDiv;
            r_shift  <= r_fifo[r_rdPtr];
          end
        end
        S_START: begin
          if (w_bitEnd) begin
            r_state  <= S_DATA;
            r_txd    <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitIdx <= 3'd0;
            r_bitCnt <= r_baudDiv;
          end else begin
            r_bitCnt <= r_bitCnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            r_bitCnt <= r_baudDiv;
            if (r_bitIdx == 3'd7) begin
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_txd    <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_bitCnt <= r_bitCnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bitEnd) begin
            if (w_pop) begin
              r_state  <= S_START;
              r_txd    <= 1'b0;
              r_bitCnt <= r_baudDiv;
              r_shift  <= r_fifo[r_rdPtr];
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bitCnt <= r_bitCnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.data_o = '0;
    if (w_rd) begin
      case (w_regSel)
        2'd1:    bus.data_o = {16'h0, 8'(r_count), 4'h0, r_overflow, w_full, w_empty, w_busy};
        2'd2:    bus.data_o = {30'h0, r_ctrl};
        2'd3:    bus.data_o = {16'h0, r_baudDiv};
        default: bus.data_o = '0;
      endcase
    end
  end

  assign uart_txd_o = r_txd;
  assign uart_int_o = r_int;

endmodule

// File: tb/tb_uart_tx_bus_slave.sv
// Self-checking bench for uart_tx_bus_slave: register vector table, a serial receiver
// feeding a byte scoreboard, and hand-written timing sequences.
module tb_uart_tx_bus_slave;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  logic irq;

  always #5 clk = ~clk;

  uart_tx_bus_slave_if bus();

  uart_tx_bus_slave #(.FIFO_DEPTH_LOG2(3), .BAUD_DIV_RESET(16'd433)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .uart_txd_o (txd),
    .uart_int_o (irq)
  );

  typedef struct {
    string       name;
    logic        ce;
    logic        we;
    logic [1:0]  regIdx;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] expData;
  } vec_t;

  int         totalChecks = 0;
  int         passedChecks = 0;
  logic [7:0] expQ[$];
  int         tbBaud = 433;
  bit         monEnable = 1'b0;
  vec_t       vecs[$];
  int         expBits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passedChecks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic vec_t mkVec(input string n, input logic ce, input logic we, input logic [1:0] r,
                                 input logic [3:0] s, input logic [31:0] w, input logic [31:0] e);
    vec_t v;
    v.name = n; v.ce = ce; v.we = we; v.regIdx = r; v.sel = s; v.wdata = w; v.expData = e;
    return v;
  endfunction

  task automatic busIdle();
    bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
  endtask

  task automatic driveBus(input logic ce, input logic we, input logic [1:0] r,
                          input logic [3:0] s, input logic [31:0] w);
    bus.ce_i = ce; bus.we_i = we; bus.addr_i = {28'h4000000, r, 2'b00};
    bus.sel_i = s; bus.data_i = w;
  endtask

  // Drives one bus cycle from a negedge; reads are checked combinationally, writes land on the next posedge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveBus(v.ce, v.we, v.regIdx, v.sel, v.wdata);
    #1;
    if (!v.we) checkOutput(v.name, bus.data_o, v.expData);
    @(posedge clk);
    #1;
    busIdle();
  endtask

  task automatic busWrite(input logic [1:0] r, input logic [3:0] s, input logic [31:0] w);
    applyStimulus(mkVec("write", 1'b1, 1'b1, r, s, w, 32'h0));
  endtask

  task automatic busRead(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    driveBus(1'b1, 1'b0, r, 4'h0, 32'h0);
    #1;
    d = bus.data_o;
    busIdle();
  endtask

  task automatic pushByte(input logic [7:0] b, input bit expectOnLine);
    busWrite(2'd0, 4'h1, {24'hDEADBE, b});
    if (expectOnLine) expQ.push_back(b);
  endtask

  // Serial receiver: finds a start bit, samples mid-bit using the bench's copy of BAUDDIV.
  initial begin : monitor
    logic [7:0] rx;
    logic       startMid;
    logic       stopBit;
    logic [7:0] expByte;
    int         bitLen;
    forever begin
      @(negedge clk);
      if (monEnable && txd === 1'b0) begin
        bitLen = tbBaud + 1;
        repeat (bitLen / 2) @(negedge clk);
        startMid = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (bitLen) @(negedge clk);
          rx[i] = txd;
        end
        repeat (bitLen) @(negedge clk);
        stopBit = txd;
        if (expQ.size() == 0) begin
          totalChecks++;
          $display("[TB] FAIL rx_unexpected_frame: got byte 0x%02h, expected no frame", rx);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("rx_start_bit", {31'h0, startMid}, 32'h0);
          checkOutput("rx_byte", {24'h0, rx}, {24'h0, expByte});
          checkOutput("rx_stop_bit", {31'h0, stopBit}, 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] d;
    int          busyCycles;
    int          intHigh;
    int          lowCycles;

    busIdle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_txd", {31'h0, txd}, 32'h1);
    checkOutput("reset_int", {31'h0, irq}, 32'h0);

    $display("[TB] register vector table");
    vecs.push_back(mkVec("rst_status",      1, 0, 2'd1, 4'h0, 32'h0,         32'h0000_0002));
    vecs.push_back(mkVec("rst_bauddiv",     1, 0, 2'd3, 4'h0, 32'h0,         32'd433));
    vecs.push_back(mkVec("rst_ctrl",        1, 0, 2'd2, 4'h0, 32'h0,         32'h0000_0001));
    vecs.push_back(mkVec("txdata_reads_0",  1, 0, 2'd0, 4'h0, 32'h0,         32'h0));
    vecs.push_back(mkVec("no_ce_reads_0",   0, 0, 2'd1, 4'h0, 32'h0,         32'h0));
    vecs.push_back(mkVec("w_ctrl_ff",       1, 1, 2'd2, 4'h1, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mkVec("ctrl_masked",     1, 0, 2'd2, 4'h0, 32'h0,         32'h0000_0003));
    vecs.push_back(mkVec("w_ctrl_nosel0",   1, 1, 2'd2, 4'hE, 32'h0,         32'h0));
    vecs.push_back(mkVec("ctrl_nosel0",     1, 0, 2'd2, 4'h0, 32'h0,         32'h0000_0003));
    vecs.push_back(mkVec("w_ctrl_1",        1, 1, 2'd2, 4'h1, 32'h1,         32'h0));
    vecs.push_back(mkVec("ctrl_1",          1, 0, 2'd2, 4'h0, 32'h0,         32'h0000_0001));
    vecs.push_back(mkVec("w_baud_lo",       1, 1, 2'd3, 4'h1, 32'h1234_5678, 32'h0));
    vecs.push_back(mkVec("baud_lo",         1, 0, 2'd3, 4'h0, 32'h0,         32'h0000_0178));
    vecs.push_back(mkVec("w_baud_hi",       1, 1, 2'd3, 4'h2, 32'h0000_AB00, 32'h0));
    vecs.push_back(mkVec("baud_hi",         1, 0, 2'd3, 4'h0, 32'h0,         32'h0000_AB78));
    vecs.push_back(mkVec("w_baud_3",        1, 1, 2'd3, 4'h3, 32'h0000_0003, 32'h0));
    vecs.push_back(mkVec("baud_3",          1, 0, 2'd3, 4'h0, 32'h0,         32'h0000_0003));
    vecs.push_back(mkVec("w_txdata_nosel0", 1, 1, 2'd0, 4'hE, 32'h0000_0077, 32'h0));
    vecs.push_back(mkVec("status_no_push",  1, 0, 2'd1, 4'h0, 32'h0,         32'h0000_0002));
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    $display("[TB] single frame 0xA5, BAUDDIV=3");
    tbBaud = 3;
    monEnable = 1'b1;
    @(negedge clk);
    driveBus(1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_00A5);
    expQ.push_back(8'hA5);
    @(posedge clk);
    #1;
    busIdle();
    checkOutput("t2_txd_at_write_edge", {31'h0, txd}, 32'h1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("t2_bit%0d_cyc%0d", b, c), {31'h0, txd}, expBits[b]);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("t2_txd_idle_after", {31'h0, txd}, 32'h1);
    busRead(2'd1, d);
    checkOutput("t2_status_after", d, 32'h0000_0002);

    $display("[TB] back-to-back frames, BAUDDIV=1");
    busWrite(2'd3, 4'h3, 32'h1);
    tbBaud = 1;
    pushByte(8'h55, 1'b1);
    pushByte(8'h0F, 1'b1);
    busyCycles = 0;
    for (int k = 0; k < 200; k++) begin
      busRead(2'd1, d);
      if (d[0]) busyCycles++;
      else break;
    end
    checkOutput("t3_busy_cycles", busyCycles, 40);
    checkOutput("t3_status_done", d, 32'h0000_0002);

    $display("[TB] overflow with transmitter disabled");
    busWrite(2'd2, 4'h1, 32'h0);
    for (int i = 1; i <= 9; i++) pushByte(8'(i * 17), i <= 8);
    busRead(2'd1, d);
    checkOutput("t4_status_full_ovf", d, 32'h0000_080C);
    busWrite(2'd1, 4'h1, 32'h8);
    busRead(2'd1, d);
    checkOutput("t4_status_ovf_clr", d, 32'h0000_0804);
    busWrite(2'd2, 4'h1, 32'h1);
    d = '0;
    for (int k = 0; k < 2000; k++) begin
      busRead(2'd1, d);
      if (d == 32'h2) break;
    end
    checkOutput("t4_drained_status", d, 32'h0000_0002);
    repeat (4) @(negedge clk);
    checkOutput("t4_sb_empty", expQ.size(), 0);

    $display("[TB] interrupt timing, BAUDDIV=2");
    busWrite(2'd3, 4'h3, 32'h2);
    tbBaud = 2;
    busWrite(2'd2, 4'h1, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_int_idle", {31'h0, irq}, 32'h1);
    @(negedge clk);
    driveBus(1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_003C);
    expQ.push_back(8'h3C);
    @(posedge clk);
    #1;
    busIdle();
    checkOutput("t5_int_at_push_edge", {31'h0, irq}, 32'h1);
    intHigh = 0;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      if (irq) intHigh++;
    end
    checkOutput("t5_int_low_in_frame", intHigh, 0);
    @(posedge clk);
    #1;
    checkOutput("t5_int_rise", {31'h0, irq}, 32'h1);
    @(negedge clk);
    driveBus(1'b1, 1'b1, 2'd2, 4'h1, 32'h1);
    @(posedge clk);
    #1;
    busIdle();
    checkOutput("t5_int_at_ctrl_edge", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("t5_int_drop", {31'h0, irq}, 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("t5_sb_empty", expQ.size(), 0);

    $display("[TB] reset during DATA with bytes queued");
    monEnable = 1'b0;
    busWrite(2'd3, 4'h3, 32'h3);
    pushByte(8'h81, 1'b0);
    pushByte(8'h42, 1'b0);
    pushByte(8'h24, 1'b0);
    repeat (8) @(posedge clk);
    busRead(2'd1, d);
    checkOutput("t6_status_before_rst", d, 32'h0000_0201);
    @(negedge clk);
    checkOutput("t6_txd_low_before_rst", {31'h0, txd}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_txd_after_rst", {31'h0, txd}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    busRead(2'd1, d);
    checkOutput("t6_status_after_rst", d, 32'h0000_0002);
    busRead(2'd2, d);
    checkOutput("t6_ctrl_after_rst", d, 32'h0000_0001);
    busRead(2'd3, d);
    checkOutput("t6_baud_after_rst", d, 32'd433);
    checkOutput("t6_int_after_rst", {31'h0, irq}, 32'h0);
    lowCycles = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) lowCycles++;
    end
    checkOutput("t6_no_frames", lowCycles, 0);

    checkOutput("final_sb_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
